// File: rtl/hm_rd_req_tx_pkg.sv
// Shared types and constants for the hm Memory Read requester.
// State encodings and TLP format/type codes live here.
package hm_rd_req_tx_pkg;

    typedef enum logic [1:0] {
        HM_TX_STATE_IDLE = 2'd0,
        HM_TX_STATE_SOF  = 2'd1,
        HM_TX_STATE_EOF  = 2'd2
    } tx_state_e;

    localparam logic [2:0] HM_FMT_3DW_NODATA = 3'b000;
    localparam logic [2:0] HM_FMT_4DW_NODATA = 3'b001;
    localparam logic [4:0] HM_TYPE_MRD       = 5'b00000;

    // Header beat: DW0 in the upper half, DW1 (requester ID, tag, byte enables) in the lower half.
    function automatic logic [63:0] mrd_header(input logic [2:0]  fmt,
                                               input logic [9:0]  len,
                                               input logic [15:0] req_id,
                                               input logic [7:0]  tag,
                                               input logic [3:0]  last_be);
        logic [31:0] dw0;
        logic [31:0] dw1;
        dw0 = {fmt, HM_TYPE_MRD, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, len};
        dw1 = {req_id, tag, last_be, 4'hF};
        return {dw0, dw1};
    endfunction

endpackage

// File: rtl/hm_rd_req_tx_if.sv
// TRN transmit bus between the requester (master) and the PCIe endpoint TX port (slave).
interface hm_rd_req_tx_if;
    logic [63:0] trn_td;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_trem_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n;
    logic [5:0]  trn_tbuf_av;
    logic        trn_terr_drop_n;
    logic        trn_tsrc_dsc_n;
    logic        trn_terrfwd_n;
    logic        trn_tstr_n;

    modport master (
        output trn_td, trn_tsof_n, trn_teof_n, trn_trem_n, trn_tsrc_rdy_n,
               trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n,
        input  trn_tdst_rdy_n, trn_tbuf_av, trn_terr_drop_n
    );

    modport slave (
        input  trn_td, trn_tsof_n, trn_teof_n, trn_trem_n, trn_tsrc_rdy_n,
               trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n,
        output trn_tdst_rdy_n, trn_tbuf_av, trn_terr_drop_n
    );
endinterface

// File: rtl/hm_tx_tag_pool.sv
// Tag pool: free bitmap with lowest-free selection, free count and release handling.
// Releases outside the pool or of already-free tags leave the bitmap unchanged.
module hm_tx_tag_pool #(
    parameter int         NUM_TAGS = 4,
    parameter logic [7:0] TAG_BASE = 8'h38,
    parameter int         IDX_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             alloc,
    input  logic             rel_valid,
    input  logic [7:0]       rel_tag,
    input  logic             drop_valid,
    input  logic [IDX_W-1:0] drop_idx,
    output logic [IDX_W-1:0] alloc_idx,
    output logic             any_free,
    output logic [5:0]       tags_free
);

    logic [NUM_TAGS-1:0] free_q;
    logic [NUM_TAGS-1:0] rel_mask;
    logic [NUM_TAGS-1:0] drop_mask;
    logic [NUM_TAGS-1:0] alloc_mask;
    logic [7:0]          rel_off;

    // Below-base tags wrap to large offsets, so one unsigned compare covers both bounds.
    assign rel_off = rel_tag - TAG_BASE;

    always_comb begin
        rel_mask   = '0;
        drop_mask  = '0;
        alloc_mask = '0;
        if (rel_valid && ({1'b0, rel_off} < 9'(NUM_TAGS)))
            rel_mask[rel_off[IDX_W-1:0]] = 1'b1;
        if (drop_valid)
            drop_mask[drop_idx] = 1'b1;
        if (alloc)
            alloc_mask[alloc_idx] = 1'b1;
    end

    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--)
            if (free_q[i]) alloc_idx = IDX_W'(i);
    end

    always_comb begin
        tags_free = '0;
        for (int i = 0; i < NUM_TAGS; i++)
            tags_free = tags_free + 6'(free_q[i]);
    end

    assign any_free = |free_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            free_q <= '1;
        else if (clr)
            free_q <= '1;
        else
            free_q <= (free_q | rel_mask | drop_mask) & ~alloc_mask;
    end

endmodule

// File: rtl/hm_rd_req_tx.sv
// PCIe Memory Read requester on the 64-bit TRN TX interface (3DW/4DW MRd, tag pool).
// Optional statistics counters are built when HM_TX_STATS_EN is defined.
module hm_rd_req_tx
    import hm_rd_req_tx_pkg::*;
#(
    parameter int         NUM_TAGS   = 4,
    parameter logic [7:0] TAG_BASE   = 8'h38,
    parameter int         TIMEOUT_W  = 16,
    parameter int         NP_BUF_BIT = 1
) (
    input  logic                  trn_clk,
    input  logic                  sys_rst,
    input  logic                  trn_reset_n,
    input  logic                  trn_lnk_up_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [63:0]           req_addr,
    input  logic [10:0]           req_len,
    output logic [7:0]            req_tag,
    output logic                  tx_end,
    output logic                  timeout,
    input  logic                  tag_rel_valid,
    input  logic [7:0]            tag_rel,
    output logic [5:0]            tags_free,
    hm_rd_req_tx_if.master        trn,
    input  logic [7:0]            cfg_bus_number,
    input  logic [4:0]            cfg_device_number,
    input  logic [2:0]            cfg_function_number,
    output logic [31:0]           stat_trn_cpt_tx,
    output logic [31:0]           stat_trn_cpt_drop,
    output logic [31:0]           stat_trn_cpt_timeout,
    output logic [1:0]            stat_state
);

    localparam int IDX_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
    // Counter value at which one more stalled SOF cycle reaches all-ones.
    localparam logic [TIMEOUT_W-1:0] TO_ARM = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    tx_state_e             state;
    logic [IDX_W-1:0]      alloc_idx;
    logic [IDX_W-1:0]      cur_idx;
    logic                  any_free;
    logic                  accept;
    logic                  to_fire;
    logic                  eof_done;
    logic                  is_4dw;
    logic [15:0]           req_id;
    logic [63:0]           beat1_d;
    logic [63:0]           beat1_q;
    logic                  rem1_q;
    logic [TIMEOUT_W-1:0]  to_cnt;
    logic [63:0]           td_q;
    logic                  tsof_q;
    logic                  teof_q;
    logic                  trem_q;
    logic                  tsrc_rdy_q;

    // Request handshake: a request transfers on a cycle with req_valid & req_ready; req_tag is
    // meaningful only then. The TRN side moves a beat on ~trn_tsrc_rdy_n & ~trn_tdst_rdy_n.
    assign req_ready = ~sys_rst & trn_reset_n & (state == HM_TX_STATE_IDLE) & ~trn_lnk_up_n
                     & |(trn.trn_tbuf_av & 6'(1 << NP_BUF_BIT)) & any_free;
    assign accept    = req_valid & req_ready;
    assign req_tag   = req_ready ? (TAG_BASE + 8'(alloc_idx)) : 8'h00;

    assign req_id  = {cfg_bus_number, cfg_device_number, cfg_function_number};
    assign is_4dw  = |req_addr[63:32];
    assign beat1_d = is_4dw ? (req_addr & ~64'h3) : {req_addr[31:0] & ~32'h3, 32'h0};

    assign to_fire  = (state == HM_TX_STATE_SOF) & trn.trn_tdst_rdy_n & (to_cnt == TO_ARM);
    assign eof_done = (state == HM_TX_STATE_EOF) & ~trn.trn_tdst_rdy_n;

    hm_tx_tag_pool #(
        .NUM_TAGS (NUM_TAGS),
        .TAG_BASE (TAG_BASE),
        .IDX_W    (IDX_W)
    ) u_pool (
        .clk        (trn_clk),
        .rst        (sys_rst),
        .clr        (~trn_reset_n),
        .alloc      (accept),
        .rel_valid  (tag_rel_valid),
        .rel_tag    (tag_rel),
        .drop_valid (to_fire),
        .drop_idx   (cur_idx),
        .alloc_idx  (alloc_idx),
        .any_free   (any_free),
        .tags_free  (tags_free)
    );

    always_ff @(posedge trn_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= HM_TX_STATE_IDLE;
            cur_idx <= '0;
            beat1_q <= '0;
            rem1_q <= 1'b1;
            to_cnt <= '0;
            td_q <= '0;
            tsof_q <= 1'b1;
            teof_q <= 1'b1;
            trem_q <= 1'b1;
            tsrc_rdy_q <= 1'b1;
            tx_end <= 1'b0;
            timeout <= 1'b0;
        end else if (!trn_reset_n) begin
            state <= HM_TX_STATE_IDLE;
            cur_idx <= '0;
            beat1_q <= '0;
            rem1_q <= 1'b1;
            to_cnt <= '0;
            td_q <= '0;
            tsof_q <= 1'b1;
            teof_q <= 1'b1;
            trem_q <= 1'b1;
            tsrc_rdy_q <= 1'b1;
            tx_end <= 1'b0;
            timeout <= 1'b0;
        end else begin
            tx_end <= 1'b0;
            timeout <= 1'b0;
            case (state)
                HM_TX_STATE_IDLE: begin
                    if (accept) begin
                        state <= HM_TX_STATE_SOF;
                        cur_idx <= alloc_idx;
                        to_cnt <= '0;
                        beat1_q <= beat1_d;
                        rem1_q <= ~is_4dw;
                        td_q <= mrd_header(is_4dw ? HM_FMT_4DW_NODATA : HM_FMT_3DW_NODATA,
                                           req_len[9:0], req_id, req_tag,
                                           (req_len == 11'd1) ? 4'h0 : 4'hF);
                        tsof_q <= 1'b0;
                        trem_q <= 1'b0;
                        tsrc_rdy_q <= 1'b0;
                    end
                end
                HM_TX_STATE_SOF: begin
                    if (!trn.trn_tdst_rdy_n) begin
                        state <= HM_TX_STATE_EOF;
                        td_q <= beat1_q;
                        tsof_q <= 1'b1;
                        teof_q <= 1'b0;
                        trem_q <= rem1_q;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (to_fire) begin
                            state <= HM_TX_STATE_IDLE;
                            td_q <= '0;
                            tsof_q <= 1'b1;
                            trem_q <= 1'b1;
                            tsrc_rdy_q <= 1'b1;
                            timeout <= 1'b1;
                        end
                    end
                end
                HM_TX_STATE_EOF: begin
                    // No abort here: once the header is taken the frame must be completed.
                    if (eof_done) begin
                        state <= HM_TX_STATE_IDLE;
                        td_q <= '0;
                        teof_q <= 1'b1;
                        trem_q <= 1'b1;
                        tsrc_rdy_q <= 1'b1;
                        tx_end <= 1'b1;
                    end
                end
                default: state <= HM_TX_STATE_IDLE;
            endcase
        end
    end

    assign trn.trn_td         = td_q;
    assign trn.trn_tsof_n     = tsof_q;
    assign trn.trn_teof_n     = teof_q;
    assign trn.trn_trem_n     = trem_q;
    assign trn.trn_tsrc_rdy_n = tsrc_rdy_q;
    assign trn.trn_tsrc_dsc_n = 1'b1;
    assign trn.trn_terrfwd_n  = 1'b1;
    assign trn.trn_tstr_n     = 1'b0;
    assign stat_state         = state;

`ifdef HM_TX_STATS_EN
    logic [31:0] cnt_tx;
    logic [31:0] cnt_drop;
    logic [31:0] cnt_to;

    always_ff @(posedge trn_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_tx <= '0;
            cnt_drop <= '0;
            cnt_to <= '0;
        end else if (!trn_reset_n) begin
            cnt_tx <= '0;
            cnt_drop <= '0;
            cnt_to <= '0;
        end else begin
            if (eof_done) cnt_tx <= cnt_tx + 32'd1;
            if (!trn.trn_terr_drop_n) cnt_drop <= cnt_drop + 32'd1;
            if (to_fire) cnt_to <= cnt_to + 32'd1;
        end
    end

    assign stat_trn_cpt_tx      = cnt_tx;
    assign stat_trn_cpt_drop    = cnt_drop;
    assign stat_trn_cpt_timeout = cnt_to;
`else
    assign stat_trn_cpt_tx      = 32'd0;
    assign stat_trn_cpt_drop    = 32'd0;
    assign stat_trn_cpt_timeout = 32'd0;
`endif

endmodule

// File: tb/tb_hm_rd_req_tx.sv
// Self-checking bench for hm_rd_req_tx: scoreboarded TRN beats plus directed tag/timeout/reset cases.
// Builds with or without HM_TX_STATS_EN.
module tb_hm_rd_req_tx;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        trn_reset_n;
    logic        trn_lnk_up_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [10:0] req_len;
    logic [7:0]  req_tag;
    logic        tx_end;
    logic        timeout;
    logic        tag_rel_valid;
    logic [7:0]  tag_rel;
    logic [5:0]  tags_free;
    logic [7:0]  cfg_bus_number      = 8'h5A;
    logic [4:0]  cfg_device_number   = 5'h13;
    logic [2:0]  cfg_function_number = 3'h6;
    logic [31:0] stat_tx;
    logic [31:0] stat_drop;
    logic [31:0] stat_to;
    logic [1:0]  stat_state;

    hm_rd_req_tx_if trn_if ();

    hm_rd_req_tx #(
        .NUM_TAGS   (4),
        .TAG_BASE   (8'h38),
        .TIMEOUT_W  (4),
        .NP_BUF_BIT (1)
    ) dut (
        .trn_clk              (clk),
        .sys_rst              (sys_rst),
        .trn_reset_n          (trn_reset_n),
        .trn_lnk_up_n         (trn_lnk_up_n),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_addr             (req_addr),
        .req_len              (req_len),
        .req_tag              (req_tag),
        .tx_end               (tx_end),
        .timeout              (timeout),
        .tag_rel_valid        (tag_rel_valid),
        .tag_rel              (tag_rel),
        .tags_free            (tags_free),
        .trn                  (trn_if),
        .cfg_bus_number       (cfg_bus_number),
        .cfg_device_number    (cfg_device_number),
        .cfg_function_number  (cfg_function_number),
        .stat_trn_cpt_tx      (stat_tx),
        .stat_trn_cpt_drop    (stat_drop),
        .stat_trn_cpt_timeout (stat_to),
        .stat_state           (stat_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_bad = 0;
    logic [65:0] exp_q[$];   // {tsof_n, teof_n, td}
    logic [0:0]  rem_q[$];
    logic [3:0]  free_m;
    int          exp_tx, exp_drop, exp_to;
    bit          rand_stall = 0;
    int          streak = 0;

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] popcnt(input logic [3:0] m);
        logic [5:0] c = 0;
        for (int i = 0; i < 4; i++) c += 6'(m[i]);
        return c;
    endfunction

    function automatic logic [31:0] stat_exp(input int v);
`ifdef HM_TX_STATS_EN
        return 32'(v);
`else
        return 32'd0 & 32'(v);
`endif
    endfunction

    function automatic logic [63:0] exp_hdr(input logic [63:0] addr, input logic [10:0] len,
                                            input logic [7:0] tag);
        logic [2:0]  fmt;
        logic [9:0]  l10;
        logic [3:0]  lbe;
        fmt = (addr[63:32] != 32'h0) ? 3'b001 : 3'b000;
        l10 = len[9:0];
        lbe = (len == 11'd1) ? 4'h0 : 4'hF;
        return {fmt, 5'b00000, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, l10,
                cfg_bus_number, cfg_device_number, cfg_function_number, tag, lbe, 4'hF};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [65:0] e;
        if (!sys_rst && trn_reset_n && !trn_if.trn_tsrc_rdy_n && !trn_if.trn_tdst_rdy_n) begin
            if (exp_q.size() == 0) begin
                check("beat_unexpected", {trn_if.trn_tsof_n, trn_if.trn_teof_n, trn_if.trn_td}, '1);
            end else begin
                e = exp_q.pop_front();
                check("beat", {trn_if.trn_tsof_n, trn_if.trn_teof_n, trn_if.trn_td}, e);
                if (!trn_if.trn_teof_n) begin
                    if (rem_q.size() == 0) check("trem_missing", 1, 0);
                    else check("trem_n", trn_if.trn_trem_n, rem_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [63:0] addr, input logic [10:0] len, input bit push,
                          output logic [7:0] tag);
        int w = 0;
        logic [7:0] etag = 8'hFF;
        req_addr = addr;
        req_len = len;
        req_valid = 1'b1;
        #1;
        while (!req_ready && w < 50) begin
            tick();
            w++;
        end
        if (!req_ready) begin
            check("req_ready_wait", req_ready, 1);
            req_valid = 1'b0;
            tag = 8'h00;
            return;
        end
        for (int i = 3; i >= 0; i--) if (free_m[i]) etag = 8'h38 + 8'(i);
        check("tags_free_pre", tags_free, popcnt(free_m));
        check("req_tag", req_tag, etag);
        tag = etag;
        if (etag != 8'hFF) free_m[etag[1:0]] = 1'b0;
        if (push) begin
            exp_q.push_back({1'b0, 1'b1, exp_hdr(addr, len, etag)});
            if (addr[63:32] != 32'h0) begin
                exp_q.push_back({1'b1, 1'b0, addr[63:2], 2'b00});
                rem_q.push_back(1'b0);
            end else begin
                exp_q.push_back({1'b1, 1'b0, addr[31:2], 2'b00, 32'h0});
                rem_q.push_back(1'b1);
            end
            exp_tx++;
        end
        tick();
        req_valid = 1'b0;
    endtask

    // Called in the cycle after accept; returns that cycle's index counted from accept.
    task automatic wait_tx_end(output int cyc);
        cyc = 1;
        while (!tx_end && cyc < 60) begin
            if (rand_stall && streak < 3 && $urandom_range(0, 2) == 0) begin
                trn_if.trn_tdst_rdy_n = 1'b1;
                streak++;
            end else begin
                trn_if.trn_tdst_rdy_n = 1'b0;
                streak = 0;
            end
            tick();
            cyc++;
        end
        check("tx_end_seen", tx_end, 1);
        check("tsrc_rdy_n_at_end", trn_if.trn_tsrc_rdy_n, 1);
        trn_if.trn_tdst_rdy_n = 1'b0;
    endtask

    task automatic rel(input logic [7:0] t);
        tag_rel_valid = 1'b1;
        tag_rel = t;
        tick();
        tag_rel_valid = 1'b0;
        if (t >= 8'h38 && t <= 8'h3B) free_m[t[1:0]] = 1'b1;
        check("tags_free_rel", tags_free, popcnt(free_m));
    endtask

    task automatic model_reset();
        free_m = 4'hF;
        exp_tx = 0;
        exp_drop = 0;
        exp_to = 0;
        exp_q.delete();
        rem_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tsrc_rdy_n"}, trn_if.trn_tsrc_rdy_n, 1);
        check({tag, "_tsof_n"}, trn_if.trn_tsof_n, 1);
        check({tag, "_teof_n"}, trn_if.trn_teof_n, 1);
        check({tag, "_trem_n"}, trn_if.trn_trem_n, 1);
        check({tag, "_td"}, trn_if.trn_td, 0);
        check({tag, "_tx_end"}, tx_end, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_req_tag"}, req_tag, 0);
        check({tag, "_tags_free"}, tags_free, 4);
        check({tag, "_state"}, stat_state, 0);
        check({tag, "_stats"}, {stat_tx, stat_drop}, 0);
        check({tag, "_stat_to"}, stat_to, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0]  t;
        logic [7:0]  tg[4];
        logic [63:0] a;
        logic [63:0] hdr;
        int          cyc, sof_cycles;
        bit          stable;

        sys_rst = 1'b1;
        trn_reset_n = 1'b1;
        trn_lnk_up_n = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        req_len = 11'd1;
        tag_rel_valid = 1'b0;
        tag_rel = 8'h00;
        trn_if.trn_tdst_rdy_n = 1'b0;
        trn_if.trn_tbuf_av = 6'h3F;
        trn_if.trn_terr_drop_n = 1'b1;
        model_reset();
        repeat (3) tick();
        check_idle_outputs("reset");
        check("tied", {trn_if.trn_tsrc_dsc_n, trn_if.trn_terrfwd_n, trn_if.trn_tstr_n}, 3'b110);
        sys_rst = 1'b0;
        tick();

        // 3DW, len 1, no stalls: tx_end three cycles after accept
        do_req(64'h0000_0000_1000_0000, 11'd1, 1, t);
        check("state_sof", stat_state, 1);
        wait_tx_end(cyc);
        check("tx_end_latency", cyc, 3);
        tick();
        check("tx_end_pulse", tx_end, 0);
        rel(t);

        // 4DW, len 1024
        do_req(64'h0000_0001_2345_6780, 11'd1024, 1, t);
        wait_tx_end(cyc);
        check("tx_end_latency_4dw", cyc, 3);
        rel(t);

        // Exhaust the pool, then a fifth request must not be accepted
        for (int i = 0; i < 4; i++) begin
            do_req(64'h0000_0000_2000_0000 + 64'(i * 64), 11'(i + 2), 1, tg[i]);
            wait_tx_end(cyc);
            check("exhaust_tag", tg[i], 8'h38 + 8'(i));
        end
        req_addr = 64'h3000;
        req_len = 11'd4;
        req_valid = 1'b1;
        repeat (3) begin
            tick();
            check("ready_when_empty", req_ready, 0);
        end
        req_valid = 1'b0;
        check("tags_free_zero", tags_free, 0);

        // Release behaviour
        rel(8'h39);
        do_req(64'h4000, 11'd8, 1, t);
        check("reuse_tag", t, 8'h39);
        wait_tx_end(cyc);
        rel(8'h20);
        rel(8'h3C);
        rel(8'h3A);
        rel(8'h3A);
        rel(8'h38);
        rel(8'h39);
        rel(8'h3B);

        // Random addresses/lengths with random destination stalls
        rand_stall = 1;
        for (int i = 0; i < 12; i++) begin
            a = {($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'h0, 32'($urandom)};
            do_req(a, 11'($urandom_range(1, 1024)), 1, t);
            wait_tx_end(cyc);
            rel(t);
        end
        rand_stall = 0;
        trn_if.trn_tdst_rdy_n = 1'b0;

        // Link down and no NP buffer block accepts; a frame in progress still completes
        trn_lnk_up_n = 1'b1;
        req_valid = 1'b1;
        #1;
        check("ready_link_down", req_ready, 0);
        tick();
        check("state_link_down", stat_state, 0);
        trn_lnk_up_n = 1'b0;
        trn_if.trn_tbuf_av = 6'h3D;
        #1;
        check("ready_no_np_buf", req_ready, 0);
        req_valid = 1'b0;
        trn_if.trn_tbuf_av = 6'h3F;
        tick();
        do_req(64'h5000, 11'd2, 1, t);
        trn_lnk_up_n = 1'b1;
        wait_tx_end(cyc);
        check("link_down_mid_frame", cyc, 3);
        trn_lnk_up_n = 1'b0;
        rel(t);

        // Dropped-TLP statistic
        trn_if.trn_terr_drop_n = 1'b0;
        repeat (3) tick();
        trn_if.trn_terr_drop_n = 1'b1;
        exp_drop += 3;

        // SOF stall timeout
        trn_if.trn_tdst_rdy_n = 1'b1;
        a = 64'h6000;
        do_req(a, 11'd16, 0, t);
        hdr = exp_hdr(a, 11'd16, t);
        sof_cycles = 0;
        stable = 1;
        while (!timeout && sof_cycles < 100) begin
            if (!trn_if.trn_tsof_n) sof_cycles++;
            if (trn_if.trn_td !== hdr) stable = 0;
            tick();
        end
        check("timeout_seen", timeout, 1);
        check("timeout_stall_cycles", sof_cycles, 15);
        check("sof_held_stable", stable, 1);
        check("timeout_src_rdy_n", trn_if.trn_tsrc_rdy_n, 1);
        check("timeout_state", stat_state, 0);
        free_m[t[1:0]] = 1'b1;
        exp_to++;
        check("timeout_tag_freed", tags_free, popcnt(free_m));
        tick();
        check("timeout_pulse", timeout, 0);
        trn_if.trn_tdst_rdy_n = 1'b0;
        check("stat_tx", stat_tx, stat_exp(exp_tx));
        check("stat_drop", stat_drop, stat_exp(exp_drop));
        check("stat_timeout", stat_to, stat_exp(exp_to));

        // Endpoint reset clears everything synchronously
        trn_if.trn_tdst_rdy_n = 1'b1;
        do_req(64'h7000, 11'd4, 0, t);
        tick();
        trn_reset_n = 1'b0;
        tick();
        model_reset();
        check_idle_outputs("trn_reset");
        trn_reset_n = 1'b1;
        trn_if.trn_tdst_rdy_n = 1'b0;
        tick();

        // Asynchronous sys_rst while EOF is stalled
        do_req(64'h0000_0002_0000_8000, 11'd32, 1, t);
        tick();
        trn_if.trn_tdst_rdy_n = 1'b1;
        check("state_eof", stat_state, 2);
        #2;
        sys_rst = 1'b1;
        #1;
        model_reset();
        check_idle_outputs("sys_rst_mid_eof");
        trn_if.trn_tdst_rdy_n = 1'b0;
        tick();
        sys_rst = 1'b0;
        tick();
        do_req(64'h8000, 11'd1, 1, t);
        wait_tx_end(cyc);
        check("post_reset_latency", cyc, 3);
        check("stat_tx_post_reset", stat_tx, stat_exp(exp_tx));
        rel(t);

        repeat (2) tick();
        check("exp_q_drained", exp_q.size(), 0);
        check("rem_q_drained", rem_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
